// File: rtl/gh_decode_bus_strobe_if.sv
// Register-bus handshake between a CPU-side master and the address decoder.
// Carries the request/address/enables in and the decoded select, strobes and status out.
interface gh_decode_bus_strobe_if #(
  parameter int N_OUT = 8
);
  localparam int AW = $clog2(N_OUT);

  logic             req;
  logic             we;
  logic [AW-1:0]    a;
  logic             g1;
  logic             g2n;
  logic             g3n;
  logic [N_OUT-1:0] sel;
  logic [N_OUT-1:0] wr_stb;
  logic [N_OUT-1:0] rd_stb;
  logic             ack;
  logic             err;
  logic             busy;

  modport master (
    output req, we, a, g1, g2n, g3n,
    input  sel, wr_stb, rd_stb, ack, err, busy
  );

  modport slave (
    input  req, we, a, g1, g2n, g3n,
    output sel, wr_stb, rd_stb, ack, err, busy
  );
endinterface

// File: rtl/gh_decode_bus_strobe.sv
// Registered N-way address decoder with wait states, abort and out-of-range error.
// Latches the address on an enabled request, holds a one-hot select, then strobes once with ack.
module gh_decode_bus_strobe #(
  parameter int N_OUT       = 8,
  parameter int WAIT_STATES = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  gh_decode_bus_strobe_if.slave bus
);
  localparam int AW = $clog2(N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STROBE, S_HOLD} state_t;

  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic             armed, armed_d;
  logic [AW-1:0]    a_q, a_d;
  logic             we_q, we_d;
  logic [N_OUT-1:0] sel_q, sel_d;
  logic [N_OUT-1:0] wr_q, wr_d;
  logic [N_OUT-1:0] rd_q, rd_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             en;

  function automatic logic [N_OUT-1:0] decode(input logic [AW-1:0] addr);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++)
      if (addr == AW'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return int'(addr) < N_OUT;
  endfunction

  assign en = bus.g1 & ~bus.g2n & ~bus.g3n;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    armed_d = armed | ~bus.req;
    a_d     = a_q;
    we_d    = we_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    wr_d    = '0;
    rd_d    = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_IDLE: begin
        // armed blocks a request that was already high when reset released
        if (armed && bus.req && en) begin
          a_d     = bus.a;
          we_d    = bus.we;
          sel_d   = decode(bus.a);
          busy_d  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.req) begin
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt == 4'd0) begin
          ack_d   = 1'b1;
          state_d = S_STROBE;
          if (in_range(a_q)) begin
            if (we_q) wr_d = decode(a_q);
            else      rd_d = decode(a_q);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (bus.req) begin
          state_d = S_HOLD;
        end else begin
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!bus.req) begin
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      armed  <= 1'b0;
      sel_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      armed  <= armed_d;
      sel_q  <= sel_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  // Latched address/direction are only consumed after acceptance, so no reset needed
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    we_q <= we_d;
  end

  assign bus.sel    = sel_q;
  assign bus.wr_stb = wr_q;
  assign bus.rd_stb = rd_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_gh_decode_bus_strobe.sv
// Bench for gh_decode_bus_strobe: four parameterisations share one clock/reset,
// directed stimulus pushes expected responses, a negedge monitor pops them on ack.
module tb_gh_decode_bus_strobe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    logic [7:0] sel;
    logic [7:0] wr;
    logic [7:0] rd;
    logic       err;
    int         cyc;
  } exp_t;
  exp_t scb[$];

  logic       req_v[4], we_v[4], g1_v[4], g2n_v[4], g3n_v[4];
  logic [2:0] a_v[4];
  logic [7:0] sel_o[4], wr_o[4], rd_o[4];
  logic       ack_o[4], err_o[4], busy_o[4];

  gh_decode_bus_strobe_if #(.N_OUT(8)) if0 ();
  gh_decode_bus_strobe_if #(.N_OUT(8)) if1 ();
  gh_decode_bus_strobe_if #(.N_OUT(6)) if2 ();
  gh_decode_bus_strobe_if #(.N_OUT(8)) if3 ();

  gh_decode_bus_strobe #(.N_OUT(8), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gh_decode_bus_strobe #(.N_OUT(8), .WAIT_STATES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gh_decode_bus_strobe #(.N_OUT(6), .WAIT_STATES(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  gh_decode_bus_strobe #(.N_OUT(8), .WAIT_STATES(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.req = req_v[0]; assign if0.we = we_v[0]; assign if0.a = a_v[0];
  assign if0.g1 = g1_v[0]; assign if0.g2n = g2n_v[0]; assign if0.g3n = g3n_v[0];
  assign if1.req = req_v[1]; assign if1.we = we_v[1]; assign if1.a = a_v[1];
  assign if1.g1 = g1_v[1]; assign if1.g2n = g2n_v[1]; assign if1.g3n = g3n_v[1];
  assign if2.req = req_v[2]; assign if2.we = we_v[2]; assign if2.a = a_v[2];
  assign if2.g1 = g1_v[2]; assign if2.g2n = g2n_v[2]; assign if2.g3n = g3n_v[2];
  assign if3.req = req_v[3]; assign if3.we = we_v[3]; assign if3.a = a_v[3];
  assign if3.g1 = g1_v[3]; assign if3.g2n = g2n_v[3]; assign if3.g3n = g3n_v[3];

  assign sel_o[0] = if0.sel; assign wr_o[0] = if0.wr_stb; assign rd_o[0] = if0.rd_stb;
  assign ack_o[0] = if0.ack; assign err_o[0] = if0.err;   assign busy_o[0] = if0.busy;
  assign sel_o[1] = if1.sel; assign wr_o[1] = if1.wr_stb; assign rd_o[1] = if1.rd_stb;
  assign ack_o[1] = if1.ack; assign err_o[1] = if1.err;   assign busy_o[1] = if1.busy;
  assign sel_o[2] = {2'b00, if2.sel}; assign wr_o[2] = {2'b00, if2.wr_stb};
  assign rd_o[2]  = {2'b00, if2.rd_stb};
  assign ack_o[2] = if2.ack; assign err_o[2] = if2.err;   assign busy_o[2] = if2.busy;
  assign sel_o[3] = if3.sel; assign wr_o[3] = if3.wr_stb; assign rd_o[3] = if3.rd_stb;
  assign ack_o[3] = if3.ack; assign err_o[3] = if3.err;   assign busy_o[3] = if3.busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [7:0] sel, input logic [7:0] wr,
                      input logic [7:0] rd, input logic err, input int at);
    exp_t e;
    e.id = id; e.sel = sel; e.wr = wr; e.rd = rd; e.err = err; e.cyc = at;
    scb.push_back(e);
  endtask

  // Full cycle with req held through the strobe, then dropped from HOLD.
  task automatic bus_cycle(input int id, input int w, input logic [2:0] a, input logic we,
                           input logic [7:0] esel, input logic [7:0] ewr,
                           input logic [7:0] erd, input logic eerr);
    a_v[id] = a; we_v[id] = we; req_v[id] = 1'b1;
    push(id, esel, ewr, erd, eerr, cyc + 2 + w);
    tick(1);
    chk($sformatf("sel_accept_d%0d", id), sel_o[id], esel);
    chk($sformatf("busy_accept_d%0d", id), busy_o[id], 1);
    tick(w + 2);
    chk($sformatf("ack_low_hold_d%0d", id), ack_o[id], 0);
    chk($sformatf("sel_hold_d%0d", id), sel_o[id], esel);
    req_v[id] = 1'b0;
    tick(1);
    chk($sformatf("sel_exit_d%0d", id), sel_o[id], 0);
    chk($sformatf("busy_exit_d%0d", id), busy_o[id], 0);
  endtask

  // Scoreboard monitor: pops one expected response per ack and checks timing/content.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack_o[i]) begin
        if (scb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack d%0d: got ack=1, expected none (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk("ack_dut_id", i, e.id);
          chk($sformatf("ack_cycle_d%0d", i), cyc, e.cyc);
          chk($sformatf("sel_at_ack_d%0d", i), sel_o[i], e.sel);
          chk($sformatf("wr_stb_d%0d", i), wr_o[i], e.wr);
          chk($sformatf("rd_stb_d%0d", i), rd_o[i], e.rd);
          chk($sformatf("err_d%0d", i), err_o[i], e.err);
        end
      end else if ((wr_o[i] != 8'h00) || (rd_o[i] != 8'h00) || err_o[i]) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_strobe d%0d: wr=0x%0h rd=0x%0h err=%0b without ack, expected 0",
                 i, wr_o[i], rd_o[i], err_o[i]);
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  logic [2:0] gpat [5];

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; a_v[i] = 3'd0;
      g1_v[i] = 1'b1; g2n_v[i] = 1'b0; g3n_v[i] = 1'b0;
    end
    gpat[0] = 3'b101; gpat[1] = 3'b000; gpat[2] = 3'b011; gpat[3] = 3'b111; gpat[4] = 3'b110;

    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_sel_d%0d", i), sel_o[i], 0);
      chk($sformatf("rst_busy_d%0d", i), busy_o[i], 0);
    end
    rst_n = 1'b1;
    tick(2);

    // W=0 write to a=5, then address boundaries
    bus_cycle(0, 0, 3'd5, 1'b1, 8'h20, 8'h20, 8'h00, 1'b0);
    bus_cycle(0, 0, 3'd0, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0);
    bus_cycle(0, 0, 3'd7, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0);

    // W=3 read a=2 with address/direction/enable changed mid-cycle
    a_v[1] = 3'd2; we_v[1] = 1'b0; req_v[1] = 1'b1;
    push(1, 8'h04, 8'h00, 8'h04, 1'b0, cyc + 5);
    tick(1);
    chk("w3_sel_e0", sel_o[1], 8'h04);
    a_v[1] = 3'd7; we_v[1] = 1'b1; g2n_v[1] = 1'b1;
    tick(3);
    chk("w3_sel_e3", sel_o[1], 8'h04);
    chk("w3_ack_e3", ack_o[1], 0);
    tick(2);
    chk("w3_sel_hold", sel_o[1], 8'h04);
    req_v[1] = 1'b0; g2n_v[1] = 1'b0;
    tick(1);
    chk("w3_sel_exit", sel_o[1], 0);
    chk("w3_busy_exit", busy_o[1], 0);

    // Enable gating: each pattern has en=0 while req is high
    a_v[0] = 3'd3; we_v[0] = 1'b0; req_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      {g1_v[0], g2n_v[0], g3n_v[0]} = gpat[k];
      tick(1);
      chk($sformatf("gated_busy_%0d", k), busy_o[0], 0);
      chk($sformatf("gated_sel_%0d", k), sel_o[0], 0);
    end
    g2n_v[0] = 1'b0;
    push(0, 8'h08, 8'h00, 8'h08, 1'b0, cyc + 2);
    tick(1);
    chk("enable_rise_sel", sel_o[0], 8'h08);
    chk("enable_rise_busy", busy_o[0], 1);
    tick(2);
    req_v[0] = 1'b0;
    tick(1);
    chk("enable_exit_busy", busy_o[0], 0);

    // N_OUT=6: out-of-range error, last and first-invalid addresses
    bus_cycle(2, 4, 3'd7, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
    bus_cycle(2, 4, 3'd5, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0);
    bus_cycle(2, 4, 3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    // Abort in WAIT: req sampled low at E0+2
    a_v[2] = 3'd1; we_v[2] = 1'b1; req_v[2] = 1'b1;
    tick(1);
    chk("abort_sel_e0", sel_o[2], 8'h02);
    chk("abort_busy_e0", busy_o[2], 1);
    tick(1);
    req_v[2] = 1'b0;
    tick(1);
    chk("abort_sel_e2", sel_o[2], 0);
    chk("abort_busy_e2", busy_o[2], 0);
    tick(6);

    // Reset mid-cycle on W=2, release with req still high
    a_v[3] = 3'd4; we_v[3] = 1'b1; req_v[3] = 1'b1;
    tick(1);
    chk("rstmid_sel_e0", sel_o[3], 8'h10);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sel_now", sel_o[3], 0);
    chk("rstmid_busy_now", busy_o[3], 0);
    chk("rstmid_ack_now", ack_o[3], 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("rst_release_busy", busy_o[3], 0);
    chk("rst_release_sel", sel_o[3], 0);
    req_v[3] = 1'b0;
    tick(1);
    bus_cycle(3, 2, 3'd4, 1'b1, 8'h10, 8'h10, 8'h00, 1'b0);

    tick(8);
    chk("scoreboard_drained", scb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gh_decode_bus_strobe.md
# gh_decode_bus_strobe

Parametrised, registered address decoder with a bus-cycle handshake for the UART core's CPU register interface. It latches an address on a request, drives a one-hot register select for the whole cycle, and inserts a programmable number of wait states. It then issues a single-cycle read or write strobe to the selected register together with an acknowledge. It generalises the fixed 3-to-8 enable-gated decode to N outputs and adds wait states, abort handling and out-of-range error reporting.

## Interface
- N_OUT, 8, number of decoded outputs (2..256, need not be a power of two); AW = $clog2(N_OUT)
- WAIT_STATES, 0, extra cycles between select and strobe (0..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous, active-low
- req  in  1  bus cycle request (level; held until ack, then dropped)
- we  in  1  1 = write cycle, 0 = read cycle; sampled with req
- a  in  AW  register address; sampled with req
- g1  in  1  enable, active high
- g2n  in  1  enable, active low
- g3n  in  1  enable, active low
- sel  out  N_OUT  one-hot registered select, held for the cycle
- wr_stb  out  N_OUT  one-cycle write strobe on the selected bit
- rd_stb  out  N_OUT  one-cycle read strobe on the selected bit
- ack  out  1  one-cycle acknowledge
- err  out  1  one-cycle error, coincident with ack, when a >= N_OUT
- busy  out  1  high from acceptance until return to IDLE

## Operation
- States: IDLE, WAIT, STROBE, HOLD. Down-counter cnt is 4 bits. An armed flag gates acceptance.
- Reset (async, immediate): state=IDLE, cnt=0, armed=0; sel, wr_stb, rd_stb, ack, err and busy are all 0.
- armed sets on any edge where req=0 and stays set. A req held high through reset release is therefore not accepted until it has been seen low once.
- Enable condition en = g1 & ~g2n & ~g3n. It is evaluated only in IDLE.
- IDLE: if armed & req & en, latch a and we, set sel[a] (all-zero if a >= N_OUT), set busy, load cnt=WAIT_STATES, and go to WAIT.
  - If req is high with en=0, the request is ignored and the state stays IDLE. A later rise of en while req is still high is accepted.
- WAIT:
  - req=0: abort. Go to IDLE, clear sel and busy, and issue no strobe, ack or err.
  - req=1 and cnt=0: go to STROBE. Assert ack for one cycle. If the latched address is in range, assert wr_stb[a] if we was latched 1, otherwise rd_stb[a]. If it is out of range, assert err and no strobe.
  - Otherwise: decrement cnt.
- STROBE (one cycle): ack, err and strobes return to 0 at the next edge. Then go to HOLD if req=1, else go to IDLE and clear sel and busy.
- HOLD: remain until req=0, then go to IDLE and clear sel and busy.
- Changes on a, we, g1, g2n or g3n after acceptance have no effect on the current cycle.
- Invariants:
  - At most one bit is set across sel, wr_stb and rd_stb combined.
  - The set strobe bit equals the set sel bit.
  - wr_stb and rd_stb are never both nonzero.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled at edge E0: sel and busy are valid after E0.
- Strobe, ack and err are high from edge E0+1+WAIT_STATES for exactly one cycle, so latency from accept to ack is WAIT_STATES+1 cycles.
- sel clears on the first edge at which req is sampled 0 in STROBE or HOLD. Minimum cycle is E0 to IDLE at E0+WAIT_STATES+2.
- Back-to-back cycles: req must be sampled low at least once between cycles (HOLD/STROBE exit). The next acceptance happens no earlier than the edge after return to IDLE.
- Abort in WAIT takes effect at the sampling edge; no partial strobe is produced.
- Reset asserted mid-cycle clears everything immediately, and a pending strobe is never emitted after release.

## Test plan
- N_OUT=8, W=0: en=1, we=1, a=5, req held. Expect sel=0x20 after E0; at E0+1 wr_stb=0x20, ack=1 for one cycle, rd_stb=0. Drop req: sel=0, busy=0 the edge after.
- W=3, read a=2: ack and rd_stb=0x04 at E0+4. sel=0x04 is stable for E0..exit; changing a mid-cycle to 7 has no effect.
- Enable gating: req=1 with g2n=1 gives no sel and busy=0 for 5 cycles. Clear g2n with req still high: accepted at that edge.
- N_OUT=6, a=7, write: sel=0, ack=1 and err=1 together, wr_stb=rd_stb=0.
- W=4, drop req at E0+2: sel and busy clear at that edge; ack, err and strobes stay 0 throughout.
- Reset: assert rst_n=0 at E0+1 of a W=2 cycle. All outputs are 0 immediately. Release with req held high: no acceptance. Take req low for one cycle, then high: normal cycle runs.
